password_entry_fsm: RTL and testbench

Front end of the password subsystem: collects decimal digits from the keypad debouncer, stores a DIGITS-long password in set mode, and compares entered digits against it in check mode. It produces the single-cycle `set_event` and `check_event` strobes and the `check_ok` result consumed by the downstream LED status stage. It also enforces an inactivity timeout and an optional failed-attempt lockout, both paced by the shared `tick_1s` strobe.

---
 rtl/password_entry_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_password_entry_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/password_entry_fsm.sv
// password_entry_fsm
// Collects keypad digits, stores a DIGITS-long password in set mode and
// compares entries against it in check mode. Entry inactivity is timed out
// on tick_1s. Optional failed-attempt lockout under PASSWORD_LOCKOUT_EN.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   tick_1s             one-cycle strobe per second
//   digit_valid, digit  keypad digit strobe and BCD value (10..15 ignored)
//   enter, clear        commit / discard strobes
//   mode_set            1 = set mode, 0 = check mode (sampled on enter)
//   set_event           one-cycle strobe, password stored
//   check_event         one-cycle strobe, check completed
//   check_ok            result of last check, held
//   pw_stored           a password has been stored since reset
//   digit_count         digits buffered (0..DIGITS)
//   locked              lockout active (tied 0 unless PASSWORD_LOCKOUT_EN)
module password_entry_fsm #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned TIMEOUT_SECONDS = 5,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCK_SECONDS    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  input  logic       mode_set,
  output logic       set_event,
  output logic       check_event,
  output logic       check_ok,
  output logic       pw_stored,
  output logic [3:0] digit_count,
  output logic       locked
);

  localparam int unsigned BUF_W = DIGITS * 4;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_SECONDS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1
`ifdef PASSWORD_LOCKOUT_EN
    , S_LOCKED = 2'd2
`endif
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [BUF_W-1:0] r_buf, w_nxt_buf;
  logic [BUF_W-1:0] r_pw, w_nxt_pw;
  logic [3:0]       r_cnt, w_nxt_cnt;
  logic [TO_W-1:0]  r_to_cnt, w_nxt_to_cnt;
  logic             r_pw_stored, w_nxt_pw_stored;
  logic             r_set_event, w_nxt_set_event;
  logic             r_check_event, w_nxt_check_event;
  logic             r_check_ok, w_nxt_check_ok;

  logic             w_full;
  logic             w_digit_ok;
  logic             w_match;
  logic [BUF_W-1:0] w_buf_shift;

`ifdef PASSWORD_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_SECONDS + 1);
  logic [FAIL_W-1:0] r_fail_cnt, w_nxt_fail_cnt;
  logic [LOCK_W-1:0] r_lock_cnt, w_nxt_lock_cnt;
  logic              r_locked, w_nxt_locked;
`endif

  assign w_full      = (r_cnt == 4'(DIGITS));
  assign w_digit_ok  = digit_valid && (digit < 4'd10) && !w_full;
  assign w_match     = r_pw_stored && w_full && (r_buf == r_pw);
  // Newest digit lands in the low nibble.
  assign w_buf_shift = (r_buf << 4) | BUF_W'(digit);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_pw          <= '0;
      r_cnt         <= '0;
      r_to_cnt      <= '0;
      r_pw_stored   <= 1'b0;
      r_set_event   <= 1'b0;
      r_check_event <= 1'b0;
      r_check_ok    <= 1'b0;
`ifdef PASSWORD_LOCKOUT_EN
      r_fail_cnt    <= '0;
      r_lock_cnt    <= '0;
      r_locked      <= 1'b0;
`endif
    end else begin
      r_state       <= w_nxt_state;
      r_buf         <= w_nxt_buf;
      r_pw          <= w_nxt_pw;
      r_cnt         <= w_nxt_cnt;
      r_to_cnt      <= w_nxt_to_cnt;
      r_pw_stored   <= w_nxt_pw_stored;
      r_set_event   <= w_nxt_set_event;
      r_check_event <= w_nxt_check_event;
      r_check_ok    <= w_nxt_check_ok;
`ifdef PASSWORD_LOCKOUT_EN
      r_fail_cnt    <= w_nxt_fail_cnt;
      r_lock_cnt    <= w_nxt_lock_cnt;
      r_locked      <= w_nxt_locked;
`endif
    end
  end

  // Next-state and next-output logic; priority clear > enter > digit > tick
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_buf         = r_buf;
    w_nxt_pw          = r_pw;
    w_nxt_cnt         = r_cnt;
    w_nxt_to_cnt      = r_to_cnt;
    w_nxt_pw_stored   = r_pw_stored;
    w_nxt_set_event   = 1'b0;
    w_nxt_check_event = 1'b0;
    w_nxt_check_ok    = r_check_ok;
`ifdef PASSWORD_LOCKOUT_EN
    w_nxt_fail_cnt    = r_fail_cnt;
    w_nxt_lock_cnt    = r_lock_cnt;
    w_nxt_locked      = r_locked;
`endif

    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (clear || enter) begin
          w_nxt_buf    = '0;
          w_nxt_cnt    = '0;
          w_nxt_to_cnt = '0;
          w_nxt_state  = S_IDLE;
        end

        if (clear) begin
          // buffer already emptied above; no event
        end else if (enter) begin
          if (mode_set) begin
            // Short entries in set mode are discarded silently
            if (w_full) begin
              w_nxt_pw        = r_buf;
              w_nxt_pw_stored = 1'b1;
              w_nxt_set_event = 1'b1;
`ifdef PASSWORD_LOCKOUT_EN
              w_nxt_fail_cnt  = '0;
`endif
            end
          end else begin
            w_nxt_check_event = 1'b1;
            w_nxt_check_ok    = w_match;
`ifdef PASSWORD_LOCKOUT_EN
            if (w_match) begin
              w_nxt_fail_cnt = '0;
            end else if (r_fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
              w_nxt_fail_cnt = FAIL_W'(MAX_FAILS);
              w_nxt_locked   = 1'b1;
              w_nxt_lock_cnt = '0;
              w_nxt_state    = S_LOCKED;
            end else begin
              w_nxt_fail_cnt = r_fail_cnt + 1'b1;
            end
`endif
          end
        end else if (w_digit_ok) begin
          w_nxt_buf    = w_buf_shift;
          w_nxt_cnt    = r_cnt + 4'd1;
          w_nxt_to_cnt = '0;
          w_nxt_state  = S_ENTRY;
        end else if ((r_state == S_ENTRY) && tick_1s) begin
          if (r_to_cnt == TO_W'(TIMEOUT_SECONDS - 1)) begin
            w_nxt_buf    = '0;
            w_nxt_cnt    = '0;
            w_nxt_to_cnt = '0;
            w_nxt_state  = S_IDLE;
          end else begin
            w_nxt_to_cnt = r_to_cnt + 1'b1;
          end
        end
      end

`ifdef PASSWORD_LOCKOUT_EN
      // Keypad input ignored; only the second tick moves us on
      S_LOCKED: begin
        if (tick_1s) begin
          if (r_lock_cnt == LOCK_W'(LOCK_SECONDS - 1)) begin
            w_nxt_lock_cnt = '0;
            w_nxt_locked   = 1'b0;
            w_nxt_fail_cnt = '0;
            w_nxt_state    = S_IDLE;
          end else begin
            w_nxt_lock_cnt = r_lock_cnt + 1'b1;
          end
        end
      end
`endif

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign set_event   = r_set_event;
  assign check_event = r_check_event;
  assign check_ok    = r_check_ok;
  assign pw_stored   = r_pw_stored;
  assign digit_count = r_cnt;

`ifdef PASSWORD_LOCKOUT_EN
  assign locked = r_locked;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{MAX_FAILS, LOCK_SECONDS};
  assign locked       = 1'b0;
`endif

endmodule

// File: tb/tb_password_entry_fsm.sv
// tb_password_entry_fsm
// Directed self-checking bench for password_entry_fsm with default
// parameters (DIGITS=4, TIMEOUT_SECONDS=5, MAX_FAILS=3, LOCK_SECONDS=10).
// Lockout sequence is exercised when PASSWORD_LOCKOUT_EN is defined.
module tb_password_entry_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1s = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       mode_set = 1'b0;
  logic       set_event;
  logic       check_event;
  logic       check_ok;
  logic       pw_stored;
  logic [3:0] digit_count;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;

  password_entry_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1s     (tick_1s),
    .digit_valid (digit_valid),
    .digit       (digit),
    .enter       (enter),
    .clear       (clear),
    .mode_set    (mode_set),
    .set_event   (set_event),
    .check_event (check_event),
    .check_ok    (check_ok),
    .pw_stored   (pw_stored),
    .digit_count (digit_count),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that updated them
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic keys4(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic press_enter(input logic set_m);
    mode_set = set_m;
    enter    = 1'b1;
    step();
    enter    = 1'b0;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_set_event", 32'(set_event), 0);
    chk("rst_check_event", 32'(check_event), 0);
    chk("rst_check_ok", 32'(check_ok), 0);
    chk("rst_pw_stored", 32'(pw_stored), 0);
    chk("rst_digit_count", 32'(digit_count), 0);
    chk("rst_locked", 32'(locked), 0);
    reset = 1'b0;
    step();

    // Check with nothing stored
    keys4(0, 0, 0, 0);
    chk("nopw_count", 32'(digit_count), 4);
    press_enter(1'b0);
    chk("nopw_event", 32'(check_event), 1);
    chk("nopw_ok", 32'(check_ok), 0);
    chk("nopw_count0", 32'(digit_count), 0);

    // Store 1234
    keys4(1, 2, 3, 4);
    press_enter(1'b1);
    chk("set_event", 32'(set_event), 1);
    chk("set_stored", 32'(pw_stored), 1);
    chk("set_count0", 32'(digit_count), 0);
    step();
    chk("set_event_1cyc", 32'(set_event), 0);

    // Correct check, result holds afterwards
    keys4(1, 2, 3, 4);
    press_enter(1'b0);
    chk("ok_event", 32'(check_event), 1);
    chk("ok_result", 32'(check_ok), 1);
    step();
    chk("ok_event_1cyc", 32'(check_event), 0);
    chk("ok_hold", 32'(check_ok), 1);

    // Wrong last digit
    keys4(1, 2, 3, 5);
    press_enter(1'b0);
    chk("bad_event", 32'(check_event), 1);
    chk("bad_result", 32'(check_ok), 0);

    // Short check fails
    key(1); key(2); key(3);
    press_enter(1'b0);
    chk("short_event", 32'(check_event), 1);
    chk("short_result", 32'(check_ok), 0);
    keys4(1, 2, 3, 4);
    press_enter(1'b0);
    chk("recover_ok", 32'(check_ok), 1);

    // Short set is discarded; stored password unchanged
    key(9); key(9); key(9);
    press_enter(1'b1);
    chk("shortset_event", 32'(set_event), 0);
    chk("shortset_count", 32'(digit_count), 0);
    keys4(1, 2, 3, 4);
    press_enter(1'b0);
    chk("shortset_keep_pw", 32'(check_ok), 1);

    // Inactivity timeout after 5 ticks
    key(1); key(2);
    tick(); tick(); tick(); tick();
    chk("to_4ticks", 32'(digit_count), 2);
    tick();
    chk("to_5ticks", 32'(digit_count), 0);
    chk("to_no_check", 32'(check_event), 0);
    chk("to_no_set", 32'(set_event), 0);

    // Digit on 4th tick restarts the timeout
    key(1); key(2);
    tick(); tick(); tick();
    digit = 4'd3; digit_valid = 1'b1; tick_1s = 1'b1;
    step();
    digit_valid = 1'b0; tick_1s = 1'b0;
    chk("restart_count", 32'(digit_count), 3);
    tick(); tick(); tick(); tick();
    chk("restart_4more", 32'(digit_count), 3);
    tick();
    chk("restart_5more", 32'(digit_count), 0);

    // clear beats enter
    keys4(1, 2, 3, 4);
    clear = 1'b1;
    press_enter(1'b0);
    clear = 1'b0;
    chk("clr_enter_event", 32'(check_event), 0);
    chk("clr_enter_count", 32'(digit_count), 0);
    chk("clr_enter_okhold", 32'(check_ok), 1);

    // enter beats same-cycle digit
    keys4(1, 2, 3, 4);
    digit = 4'd7; digit_valid = 1'b1;
    press_enter(1'b0);
    digit_valid = 1'b0;
    chk("ent_dig_event", 32'(check_event), 1);
    chk("ent_dig_ok", 32'(check_ok), 1);
    chk("ent_dig_count", 32'(digit_count), 0);

    // Non-BCD digit ignored
    key(4'd10);
    chk("bcd10_idle", 32'(digit_count), 0);
    key(1); key(2); key(3); key(4'd10);
    chk("bcd10_count", 32'(digit_count), 3);
    key(4);
    press_enter(1'b0);
    chk("bcd10_ok", 32'(check_ok), 1);

    // Digit beyond DIGITS dropped
    keys4(1, 2, 3, 4);
    key(5);
    chk("full_count", 32'(digit_count), 4);
    press_enter(1'b0);
    chk("full_ok", 32'(check_ok), 1);

    // Back-to-back enters: second sees empty buffer
    keys4(1, 2, 3, 4);
    mode_set = 1'b0;
    enter = 1'b1;
    step();
    chk("b2b_ev1", 32'(check_event), 1);
    chk("b2b_ok1", 32'(check_ok), 1);
    step();
    enter = 1'b0;
    chk("b2b_ev2", 32'(check_event), 1);
    chk("b2b_ok2", 32'(check_ok), 0);

    // Plain clear
    key(5); key(6);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_count", 32'(digit_count), 0);
    chk("clear_no_event", 32'(check_event), 0);

    // Mid-operation reset erases stored password
    key(1); key(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_stored", 32'(pw_stored), 0);
    chk("mrst_count", 32'(digit_count), 0);
    keys4(1, 2, 3, 4);
    press_enter(1'b0);
    chk("mrst_check_fail", 32'(check_ok), 0);

    // Three wrong checks
    keys4(1, 2, 3, 4);
    press_enter(1'b1);
    chk("lk_set", 32'(set_event), 1);
    for (int i = 0; i < 2; i++) begin
      keys4(1, 1, 1, 1);
      press_enter(1'b0);
      chk("lk_pre_locked", 32'(locked), 0);
    end
    keys4(1, 1, 1, 1);
    press_enter(1'b0);
    chk("lk_3rd_event", 32'(check_event), 1);
`ifdef PASSWORD_LOCKOUT_EN
    chk("lk_3rd_locked", 32'(locked), 1);
    key(1); key(2);
    chk("lk_ignore_digit", 32'(digit_count), 0);
    press_enter(1'b0);
    chk("lk_ignore_enter", 32'(check_event), 0);
    for (int i = 0; i < 9; i++) tick();
    chk("lk_9ticks", 32'(locked), 1);
    tick();
    chk("lk_10ticks", 32'(locked), 0);
`else
    chk("nolk_locked", 32'(locked), 0);
`endif
    keys4(1, 2, 3, 4);
    press_enter(1'b0);
    chk("lk_after_event", 32'(check_event), 1);
    chk("lk_after_ok", 32'(check_ok), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
